// File: rtl/trisc_control_unit.sv
// TRISC control unit: fetch/decode/execute sequencer for the eight-opcode set.
// Latency: one state per clock; Moore strobes from state, Mealy strobes follow MRDY in-cycle.
// Backpressure: F1, RD and WR hold (outputs stable) while MRDY is low.
module trisc_control_unit (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic       RUN,
    input  logic [2:0] OPCODE,
    input  logic       AZ,
    input  logic       MRDY,
    output logic       PC_CLR,
    output logic       PC_INC,
    output logic       PC_LD,
    output logic       MAR_PC,
    output logic       MAR_IR,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       IR_LD,
    output logic       ACC_LD,
    output logic       ACC_ADD,
    output logic       ACC_INC,
    output logic       ACC_CLR,
    output logic       FETCH,
    output logic       HALTED
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_F0   = 4'd1;
    localparam logic [3:0] S_F1   = 4'd2;
    localparam logic [3:0] S_DEC  = 4'd3;
    localparam logic [3:0] S_ADR  = 4'd4;
    localparam logic [3:0] S_RD   = 4'd5;
    localparam logic [3:0] S_WR   = 4'd6;
    localparam logic [3:0] S_XINC = 4'd7;
    localparam logic [3:0] S_XCLR = 4'd8;
    localparam logic [3:0] S_XJMP = 4'd9;
    localparam logic [3:0] S_HLT  = 4'd10;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_STA  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_INCA = 3'b100;
    localparam logic [2:0] OP_CLRA = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    // Latched memory op uses the low opcode bits; 00 means "no memory op".
    localparam logic [1:0] LOP_LDA = 2'b01;
    localparam logic [1:0] LOP_STA = 2'b10;
    localparam logic [1:0] LOP_ADD = 2'b11;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [1:0] lop;

    // State register; CLR_n forces RST at once so no write strobe survives reset.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the memory-op kind in DEC so ADR/RD/WR need not see OPCODE again.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            lop <= 2'b00;
        end else if (state == S_DEC) begin
            lop <= OPCODE[2] ? 2'b00 : OPCODE[1:0];
        end
    end

    // Next-state selection; unused encodings recover to RST.
    always_comb begin
        state_nxt = S_RST;
        case (state)
            S_RST:  state_nxt = RUN ? S_F0 : S_RST;
            S_F0:   state_nxt = S_F1;
            S_F1:   state_nxt = MRDY ? S_DEC : S_F1;
            S_DEC: begin
                case (OPCODE)
                    OP_HLT:  state_nxt = S_HLT;
                    OP_LDA,
                    OP_STA,
                    OP_ADD:  state_nxt = S_ADR;
                    OP_INCA: state_nxt = S_XINC;
                    OP_CLRA: state_nxt = S_XCLR;
                    OP_JMP:  state_nxt = S_XJMP;
                    OP_JZ:   state_nxt = AZ ? S_XJMP : S_F0;
                    default: state_nxt = S_RST;
                endcase
            end
            S_ADR:  state_nxt = (lop == LOP_STA) ? S_WR : S_RD;
            S_RD:   state_nxt = MRDY ? S_F0 : S_RD;
            S_WR:   state_nxt = MRDY ? S_F0 : S_WR;
            S_XINC: state_nxt = S_F0;
            S_XCLR: state_nxt = S_F0;
            S_XJMP: state_nxt = S_F0;
            S_HLT:  state_nxt = S_HLT;
            default: state_nxt = S_RST;
        endcase
    end

    // Output decode: Moore strobes from state, Mealy transfer strobes gated by MRDY.
    always_comb begin
        PC_CLR  = 1'b0;
        PC_INC  = 1'b0;
        PC_LD   = 1'b0;
        MAR_PC  = 1'b0;
        MAR_IR  = 1'b0;
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
        IR_LD   = 1'b0;
        ACC_LD  = 1'b0;
        ACC_ADD = 1'b0;
        ACC_INC = 1'b0;
        ACC_CLR = 1'b0;
        FETCH   = 1'b0;
        HALTED  = 1'b0;
        case (state)
            S_RST:  PC_CLR = 1'b1;
            S_F0: begin
                MAR_PC = 1'b1;
                FETCH  = 1'b1;
            end
            S_F1: begin
                MEM_RD = 1'b1;
                FETCH  = 1'b1;
                IR_LD  = MRDY;
                PC_INC = MRDY;
            end
            S_ADR:  MAR_IR = 1'b1;
            S_RD: begin
                MEM_RD  = 1'b1;
                ACC_LD  = MRDY && ((lop == LOP_LDA) || (lop == LOP_ADD));
                ACC_ADD = MRDY && (lop == LOP_ADD);
            end
            S_WR:   MEM_WR  = 1'b1;
            S_XINC: ACC_INC = 1'b1;
            S_XCLR: ACC_CLR = 1'b1;
            S_XJMP: PC_LD   = 1'b1;
            S_HLT:  HALTED  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trisc_control_unit.sv
// Bench for trisc_control_unit: per-instruction expected strobe tables vs. DUT.
// Latency: one table row per clock, sampled on the falling edge.
// Backpressure: MRDY wait counts are chosen per instruction and built into the table.
module tb_trisc_control_unit;

    logic       clk = 1'b0;
    logic       CLR_n;
    logic       RUN;
    logic [2:0] OPCODE;
    logic       AZ;
    logic       MRDY;
    logic       PC_CLR, PC_INC, PC_LD, MAR_PC, MAR_IR, MEM_RD, MEM_WR;
    logic       IR_LD, ACC_LD, ACC_ADD, ACC_INC, ACC_CLR, FETCH, HALTED;

    int total = 0;
    int bad   = 0;

    // Output vector bit masks.
    localparam logic [13:0] M_PC_CLR  = 14'h2000;
    localparam logic [13:0] M_PC_INC  = 14'h1000;
    localparam logic [13:0] M_PC_LD   = 14'h0800;
    localparam logic [13:0] M_MAR_PC  = 14'h0400;
    localparam logic [13:0] M_MAR_IR  = 14'h0200;
    localparam logic [13:0] M_MEM_RD  = 14'h0100;
    localparam logic [13:0] M_MEM_WR  = 14'h0080;
    localparam logic [13:0] M_IR_LD   = 14'h0040;
    localparam logic [13:0] M_ACC_LD  = 14'h0020;
    localparam logic [13:0] M_ACC_ADD = 14'h0010;
    localparam logic [13:0] M_ACC_INC = 14'h0008;
    localparam logic [13:0] M_ACC_CLR = 14'h0004;
    localparam logic [13:0] M_FETCH   = 14'h0002;
    localparam logic [13:0] M_HALTED  = 14'h0001;

    logic [13:0] obs;
    assign obs = {PC_CLR, PC_INC, PC_LD, MAR_PC, MAR_IR, MEM_RD, MEM_WR,
                  IR_LD, ACC_LD, ACC_ADD, ACC_INC, ACC_CLR, FETCH, HALTED};

    trisc_control_unit dut (
        .clk(clk), .CLR_n(CLR_n), .RUN(RUN), .OPCODE(OPCODE), .AZ(AZ), .MRDY(MRDY),
        .PC_CLR(PC_CLR), .PC_INC(PC_INC), .PC_LD(PC_LD), .MAR_PC(MAR_PC),
        .MAR_IR(MAR_IR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IR_LD(IR_LD),
        .ACC_LD(ACC_LD), .ACC_ADD(ACC_ADD), .ACC_INC(ACC_INC), .ACC_CLR(ACC_CLR),
        .FETCH(FETCH), .HALTED(HALTED)
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: entered 1 time unit after a rising edge, drives inputs,
    // checks outputs at the falling edge, returns 1 unit after the next rising edge.
    task automatic cycle(input logic mrdy, input logic [2:0] op, input logic az,
                         input logic run, input logic [13:0] exp, input string name);
        MRDY   = mrdy;
        OPCODE = op;
        AZ     = az;
        RUN    = run;
        @(negedge clk);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: outputs=%014b expected=%014b", name, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Expected behaviour of one instruction from F0 onward, with w1 stall
    // cycles in F1 and wm stall cycles in the RD/WR data transfer.
    task automatic run_instr(input logic [2:0] op, input logic az,
                             input int w1, input int wm, input string name);
        logic [13:0] last;
        cycle(rbit(), 3'($urandom), rbit(), rbit(), M_MAR_PC | M_FETCH, {name, ":F0"});
        for (int i = 0; i < w1; i++)
            cycle(1'b0, 3'($urandom), rbit(), rbit(), M_MEM_RD | M_FETCH, {name, ":F1wait"});
        cycle(1'b1, 3'($urandom), rbit(), rbit(),
              M_MEM_RD | M_FETCH | M_IR_LD | M_PC_INC, {name, ":F1"});
        cycle(rbit(), op, az, rbit(), 14'h0, {name, ":DEC"});
        case (op)
            3'b001, 3'b010, 3'b011: begin
                cycle(rbit(), 3'($urandom), rbit(), rbit(), M_MAR_IR, {name, ":ADR"});
                last = (op == 3'b010) ? M_MEM_WR : M_MEM_RD;
                for (int i = 0; i < wm; i++)
                    cycle(1'b0, 3'($urandom), rbit(), rbit(), last, {name, ":MEMwait"});
                if (op == 3'b001) last = last | M_ACC_LD;
                if (op == 3'b011) last = last | M_ACC_LD | M_ACC_ADD;
                cycle(1'b1, 3'($urandom), rbit(), rbit(), last, {name, ":MEM"});
            end
            3'b100: cycle(rbit(), 3'($urandom), rbit(), rbit(), M_ACC_INC, {name, ":XINC"});
            3'b101: cycle(rbit(), 3'($urandom), rbit(), rbit(), M_ACC_CLR, {name, ":XCLR"});
            3'b110: cycle(rbit(), 3'($urandom), rbit(), rbit(), M_PC_LD, {name, ":XJMP"});
            3'b111: if (az) cycle(rbit(), 3'($urandom), rbit(), rbit(), M_PC_LD, {name, ":JZtaken"});
            default: ;
        endcase
    endtask

    // Release from reset sitting in RST, then sample RUN high once.
    task automatic start_from_rst(input string name);
        CLR_n = 1'b1;
        cycle(rbit(), 3'($urandom), rbit(), 1'b0, M_PC_CLR, {name, ":idle"});
        cycle(rbit(), 3'($urandom), rbit(), 1'b1, M_PC_CLR, {name, ":run"});
    endtask

    task automatic test_reset();
        CLR_n = 1'b0;
        RUN = 1'b0; MRDY = 1'b0; OPCODE = 3'b000; AZ = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            cycle(rbit(), 3'($urandom), rbit(), 1'b0, M_PC_CLR, "reset_held");
        CLR_n = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(rbit(), 3'($urandom), rbit(), 1'b0, M_PC_CLR, "rst_no_run");
        cycle(rbit(), 3'($urandom), rbit(), 1'b1, M_PC_CLR, "rst_run");
    endtask

    task automatic test_inca();
        run_instr(3'b100, 1'b0, 0, 0, "inca");
    endtask

    task automatic test_lda_stall();
        run_instr(3'b001, 1'b0, 0, 2, "lda_stall");
    endtask

    task automatic test_back_to_back();
        run_instr(3'b011, 1'b0, 0, 0, "add");
        run_instr(3'b010, 1'b0, 0, 0, "sta");
    endtask

    task automatic test_jz();
        run_instr(3'b111, 1'b1, 0, 0, "jz_az1");
        run_instr(3'b111, 1'b0, 0, 0, "jz_az0");
        run_instr(3'b110, 1'b0, 1, 0, "jmp");
        run_instr(3'b101, 1'b0, 0, 0, "clra");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(1, 7));
            run_instr(op, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_reset_mid_wr();
        cycle(1'b1, 3'b000, 1'b0, 1'b0, M_MAR_PC | M_FETCH, "rwr:F0");
        cycle(1'b1, 3'b000, 1'b0, 1'b0, M_MEM_RD | M_FETCH | M_IR_LD | M_PC_INC, "rwr:F1");
        cycle(1'b1, 3'b010, 1'b0, 1'b0, 14'h0, "rwr:DEC");
        cycle(1'b0, 3'b000, 1'b0, 1'b0, M_MAR_IR, "rwr:ADR");
        cycle(1'b0, 3'b000, 1'b0, 1'b0, M_MEM_WR, "rwr:WRwait");
        MRDY = 1'b0;
        #2;
        CLR_n = 1'b0;
        #1;
        total++;
        if (obs !== M_PC_CLR) begin
            bad++;
            $display("FAIL rwr_async: outputs=%014b expected=%014b", obs, M_PC_CLR);
        end
        @(posedge clk);
        #1;
        cycle(1'b1, 3'b010, 1'b0, 1'b0, M_PC_CLR, "rwr:in_reset");
        start_from_rst("rwr_restart");
        run_instr(3'b100, 1'b0, 0, 0, "rwr_inca");
    endtask

    task automatic test_hlt();
        run_instr(3'b000, 1'b0, 1, 0, "hlt");
        for (int i = 0; i < 10; i++)
            cycle(rbit(), 3'($urandom), rbit(), 1'(i & 1), M_HALTED, "hlt_hold");
        CLR_n = 1'b0;
        cycle(rbit(), 3'($urandom), rbit(), 1'b1, M_PC_CLR, "hlt_reset");
        start_from_rst("hlt_restart");
        run_instr(3'b110, 1'b0, 0, 0, "hlt_jmp");
    endtask

    initial begin
        test_reset();
        test_inca();
        test_lda_stall();
        test_back_to_back();
        test_jz();
        test_random();
        test_reset_mid_wr();
        test_hlt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
